foc_sample_driver: RTL
======================

Name: foc_sample_driver

Overview:
- Initiator side of the `top` controller's sample/coefficient interface; sits between the ADC/resolver capture logic and `top`.
- After reset, and on request, it writes the PID coefficient set into `top`'s d and q coefficient ports.
- It then forwards each ADC sample strobe to `top` as a held `valid` burst and waits for `top`'s `ready` rising edge before issuing the next sample.
- It counts dropped samples and flags a ready timeout.

Parameters:
- D_WIDTH, 19, data width of currents, angle, coefficients and addresses.
- Q_BITS, 15, fractional bits of the fixed-point format (informational; no rescaling inside this block).
- VALID_HOLD, 4, cycles `valid` is held high per issued sample (must be ≥1).
- TIMEOUT, 1024, maximum WAIT_READY cycles before a fault is declared.
- CNT_W, 8, width of the overrun counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- adc_strobe  in  1  one-cycle pulse: new sample present on the `adc_*` / `res_angle` inputs.
- adcA_in, adcB_in  in  D_WIDTH each  phase A/B currents, two's complement.
- res_angle  in  D_WIDTH  resolver angle.
- torque_req  in  D_WIDTH  signed target current.
- kp_in, ki_in, kd_in  in  D_WIDTH each  coefficient shadow values.
- cfg_update  in  1  pulse requesting a coefficient reload.
- ready  in  1  completion indication from `top`.
- valid  out  1  sample valid to `top`.
- currA_out, currB_out, currC_out  out  D_WIDTH each  held phase currents.
- angle_out  out  D_WIDTH  held angle.
- currT_out  out  D_WIDTH  held target current.
- pid_d_wen, pid_q_wen  out  1 each  coefficient write enables.
- pid_d_addr, pid_q_addr  out  D_WIDTH each  coefficient address (0=Kp, 1=Ki, 2=Kd).
- pid_d_data, pid_q_data  out  D_WIDTH each  coefficient data.
- busy  out  1  high in every state except WAIT_SAMPLE.
- overrun_cnt  out  CNT_W  saturating count of dropped strobes.
- timeout_fault  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to LOAD with load index 0.
  - valid, both wen, busy-internal counters, overrun_cnt and timeout_fault go to 0.
  - All data and address outputs go to 0.
  - Reset mid-operation aborts any burst or load immediately; valid is low the next cycle.
- LOAD (3 cycles):
  - Cycle k (k=0,1,2): pid_d_wen = pid_q_wen = 1, both addresses = k, both data = kp/ki/kd respectively, sampled combinationally from the `k*_in` inputs of that cycle and registered.
  - After k=2, wen drops to 0 and the state moves to WAIT_SAMPLE.
  - d and q always receive identical values.
- WAIT_SAMPLE:
  - On adc_strobe, register adcA→currA_out, adcB→currB_out, currC_out = −(adcA+adcB) truncated to D_WIDTH (wraps, no saturation), angle and torque_req.
  - Then set valid=1 and enter ISSUE.
  - If cfg_update and adc_strobe arrive together, the reload wins and the strobe counts as an overrun.
  - cfg_update alone enters LOAD.
- ISSUE:
  - valid held high exactly VALID_HOLD cycles; data outputs stable throughout.
  - Then valid=0, timer cleared, enter WAIT_READY.
- WAIT_READY:
  - Exits to WAIT_SAMPLE on the first cycle where ready=1 and the previous-cycle ready=0 (rising edge).
  - ready already high on entry does not count.
  - Timer increments each cycle; on reaching TIMEOUT, set timeout_fault=1 and go to WAIT_SAMPLE.
- Overrun: adc_strobe in any state other than WAIT_SAMPLE increments overrun_cnt, saturating at 2^CNT_W−1. The sample is discarded and the held outputs are unchanged.
- cfg_update outside WAIT_SAMPLE is latched pending and serviced on the next entry to WAIT_SAMPLE, before any strobe. LOAD entry itself counts as servicing.
- Latency: strobe at edge N gives valid=1 from edge N+1 through edge N+VALID_HOLD.

Test Plan:
- Reset release with kp=4096, ki=512, kd=0 → three consecutive cycles with wen=1 and addr 0/1/2, data 4096/512/0 on both d and q; then wen=0 and busy=0.
- Strobe with adcA=16384, adcB=−16384 → valid high exactly 4 cycles, currC_out=0, outputs stable; ready pulse 10 cycles later → busy=0.
- Strobe with adcA=adcB=16384 → currC_out = −32768 (0x78000 in 19 bits).
- Two strobes during WAIT_READY → overrun_cnt=2 and held data unchanged; 300 strobes with CNT_W=8 → saturates at 255.
- ready tied high before and through the burst → no exit until TIMEOUT cycles, then timeout_fault=1 and it persists until rst.
- cfg_update during ISSUE → after ready, LOAD runs before the next strobe is accepted; rst asserted mid-ISSUE → valid=0 the next cycle and LOAD restarts.

Source files
------------

// File: rtl/foc_sample_driver.sv
// foc_sample_driver
// Initiator side of the controller's sample/coefficient interface. After reset
// (and whenever a reload is requested) it writes Kp/Ki/Kd into both the d and q
// coefficient ports, then forwards each ADC strobe as a held valid burst and
// waits for a rising edge on ready before it accepts the next sample. Strobes
// that arrive while the block is busy are dropped and counted, and a missing
// ready produces a sticky timeout fault.

module foc_sample_driver #(
   parameter int D_WIDTH    = 19,
   parameter int Q_BITS     = 15,
   parameter int VALID_HOLD = 4,
   parameter int TIMEOUT    = 1024,
   parameter int CNT_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               adc_strobe,
   input  logic [D_WIDTH-1:0] adcA_in,
   input  logic [D_WIDTH-1:0] adcB_in,
   input  logic [D_WIDTH-1:0] res_angle,
   input  logic [D_WIDTH-1:0] torque_req,
   input  logic [D_WIDTH-1:0] kp_in,
   input  logic [D_WIDTH-1:0] ki_in,
   input  logic [D_WIDTH-1:0] kd_in,
   input  logic               cfg_update,
   input  logic               ready,
   output logic               valid,
   output logic [D_WIDTH-1:0] currA_out,
   output logic [D_WIDTH-1:0] currB_out,
   output logic [D_WIDTH-1:0] currC_out,
   output logic [D_WIDTH-1:0] angle_out,
   output logic [D_WIDTH-1:0] currT_out,
   output logic               pid_d_wen,
   output logic               pid_q_wen,
   output logic [D_WIDTH-1:0] pid_d_addr,
   output logic [D_WIDTH-1:0] pid_q_addr,
   output logic [D_WIDTH-1:0] pid_d_data,
   output logic [D_WIDTH-1:0] pid_q_data,
   output logic               busy,
   output logic [CNT_W-1:0]   overrun_cnt,
   output logic               timeout_fault
);

   // Q_BITS only documents the fixed-point format; the check below refuses
   // parameter sets that would make the format or the valid burst meaningless.
   if (VALID_HOLD < 1 || Q_BITS >= D_WIDTH || TIMEOUT < 1) begin : gParamCheck
      $error("foc_sample_driver: illegal parameter combination");
   end

   localparam int HOLD_W = $clog2(VALID_HOLD + 1);
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_WAIT_SAMPLE,
      ST_ISSUE,
      ST_WAIT_READY
   } StateT;

   // Control registers
   StateT              r_state;
   logic [1:0]         r_loadIdx;
   logic [HOLD_W-1:0]  r_holdCnt;
   logic [TMR_W-1:0]   r_timer;
   logic               r_readyPrev;
   logic               r_cfgPending;
   logic               r_valid;
   logic               r_wen;
   logic [D_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] r_data;
   logic               r_timeoutFault;

   // Held sample and drop counter
   logic [D_WIDTH-1:0] r_currA;
   logic [D_WIDTH-1:0] r_currB;
   logic [D_WIDTH-1:0] r_currC;
   logic [D_WIDTH-1:0] r_angle;
   logic [D_WIDTH-1:0] r_currT;
   logic [CNT_W-1:0]   r_overrunCnt;

   // Next-state values from the FSM decode
   StateT              w_nextState;
   logic [1:0]         w_nextLoadIdx;
   logic [HOLD_W-1:0]  w_nextHoldCnt;
   logic [TMR_W-1:0]   w_nextTimer;
   logic               w_nextPending;
   logic               w_nextValid;
   logic               w_nextWen;
   logic [D_WIDTH-1:0] w_nextAddr;
   logic [D_WIDTH-1:0] w_nextData;
   logic               w_nextFault;
   logic               w_capture;
   logic               w_drop;

   logic [D_WIDTH-1:0] w_coef;
   logic [D_WIDTH-1:0] w_currC;
   logic               w_readyRise;

   // Third phase current is the negated sum of A and B; it wraps rather than
   // saturates, matching the two's complement width of the bus.
   assign w_currC = -(adcA_in + adcB_in);

   // Only a rising edge of ready completes a sample, so a level left high
   // from a previous transaction cannot release the next one.
   assign w_readyRise = ready & ~r_readyPrev;

   // Select the coefficient for the current load index: 0=Kp, 1=Ki, 2=Kd.
   always_comb begin
      w_coef = kd_in;
      case (r_loadIdx)
         2'd0:    w_coef = kp_in;
         2'd1:    w_coef = ki_in;
         default: w_coef = kd_in;
      endcase
   end

   // Next-state and registered-output decode for the load/issue/handshake FSM.
   always_comb begin
      w_nextState   = r_state;
      w_nextLoadIdx = r_loadIdx;
      w_nextHoldCnt = r_holdCnt;
      w_nextTimer   = r_timer;
      w_nextPending = r_cfgPending;
      w_nextValid   = r_valid;
      w_nextWen     = 1'b0;
      w_nextAddr    = r_addr;
      w_nextData    = r_data;
      w_nextFault   = r_timeoutFault;
      w_capture     = 1'b0;
      w_drop        = 1'b0;

      case (r_state)
         ST_LOAD: begin
            w_nextWen  = 1'b1;
            w_nextAddr = {{(D_WIDTH-2){1'b0}}, r_loadIdx};
            w_nextData = w_coef;
            w_drop     = adc_strobe;
            if (cfg_update) begin
               w_nextPending = 1'b1;
            end
            if (r_loadIdx == 2'd2) begin
               w_nextLoadIdx = 2'd0;
               w_nextState   = ST_WAIT_SAMPLE;
            end else begin
               w_nextLoadIdx = r_loadIdx + 2'd1;
            end
         end

         ST_WAIT_SAMPLE: begin
            if (cfg_update || r_cfgPending) begin
               w_nextPending = 1'b0;
               w_nextLoadIdx = 2'd0;
               w_nextState   = ST_LOAD;
               w_drop        = adc_strobe;
            end else if (adc_strobe) begin
               w_capture     = 1'b1;
               w_nextValid   = 1'b1;
               w_nextHoldCnt = HOLD_W'(1);
               w_nextState   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            w_drop = adc_strobe;
            if (cfg_update) begin
               w_nextPending = 1'b1;
            end
            if (r_holdCnt == HOLD_W'(VALID_HOLD)) begin
               w_nextValid = 1'b0;
               w_nextTimer = '0;
               w_nextState = ST_WAIT_READY;
            end else begin
               w_nextHoldCnt = r_holdCnt + HOLD_W'(1);
            end
         end

         ST_WAIT_READY: begin
            w_drop = adc_strobe;
            if (cfg_update) begin
               w_nextPending = 1'b1;
            end
            if (w_readyRise) begin
               w_nextState = ST_WAIT_SAMPLE;
            end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
               w_nextFault = 1'b1;
               w_nextState = ST_WAIT_SAMPLE;
            end else begin
               w_nextTimer = r_timer + TMR_W'(1);
            end
         end

         default: begin
            w_nextLoadIdx = 2'd0;
            w_nextState   = ST_LOAD;
         end
      endcase
   end

   // State register plus the control outputs that follow the FSM decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_LOAD;
         r_loadIdx      <= 2'd0;
         r_holdCnt      <= '0;
         r_timer        <= '0;
         r_readyPrev    <= 1'b0;
         r_cfgPending   <= 1'b0;
         r_valid        <= 1'b0;
         r_wen          <= 1'b0;
         r_addr         <= '0;
         r_data         <= '0;
         r_timeoutFault <= 1'b0;
      end else begin
         r_state        <= w_nextState;
         r_loadIdx      <= w_nextLoadIdx;
         r_holdCnt      <= w_nextHoldCnt;
         r_timer        <= w_nextTimer;
         r_readyPrev    <= ready;
         r_cfgPending   <= w_nextPending;
         r_valid        <= w_nextValid;
         r_wen          <= w_nextWen;
         r_addr         <= w_nextAddr;
         r_data         <= w_nextData;
         r_timeoutFault <= w_nextFault;
      end
   end

   // Capture an accepted sample; dropped strobes leave the held values alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_currA <= '0;
         r_currB <= '0;
         r_currC <= '0;
         r_angle <= '0;
         r_currT <= '0;
      end else if (w_capture) begin
         r_currA <= adcA_in;
         r_currB <= adcB_in;
         r_currC <= w_currC;
         r_angle <= res_angle;
         r_currT <= torque_req;
      end
   end

   // Count dropped strobes, sticking at the all-ones value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overrunCnt <= '0;
      end else if (w_drop && (r_overrunCnt != '1)) begin
         r_overrunCnt <= r_overrunCnt + CNT_W'(1);
      end
   end

   assign valid         = r_valid;
   assign currA_out     = r_currA;
   assign currB_out     = r_currB;
   assign currC_out     = r_currC;
   assign angle_out     = r_angle;
   assign currT_out     = r_currT;
   assign pid_d_wen     = r_wen;
   assign pid_q_wen     = r_wen;
   assign pid_d_addr    = r_addr;
   assign pid_q_addr    = r_addr;
   assign pid_d_data    = r_data;
   assign pid_q_data    = r_data;
   assign busy          = (r_state != ST_WAIT_SAMPLE);
   assign overrun_cnt   = r_overrunCnt;
   assign timeout_fault = r_timeoutFault;

endmodule
